// File: rtl/common_types_pkg.sv
// Shared types for the memory arbiter: access sizes (also the dwrite encoding)
// and the arbiter FSM states.
package common_types_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    BYTE = 2'd1,
    HALF = 2'd2,
    WORD = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store lane steering: replicates store data across byte lanes,
// builds the write strobes and flags accesses that break natural alignment.
module store_align
  import common_types_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_dstore,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_strb,
  output logic        o_misaligned
);

  // Lane replication, strobe generation and alignment check per access size
  always_comb begin
    o_wdata      = 32'd0;
    o_strb       = 4'd0;
    o_misaligned = 1'b0;
    case (mem_size_t'(i_size))
      BYTE: begin
        o_wdata = {4{i_dstore[7:0]}};
        o_strb  = 4'b0001 << i_addr;
      end
      HALF: begin
        o_wdata      = {2{i_dstore[15:0]}};
        o_strb       = 4'b0011 << i_addr;
        o_misaligned = i_addr[0];
      end
      WORD: begin
        o_wdata      = i_dstore;
        o_strb       = 4'b1111;
        o_misaligned = (i_addr != 2'b00);
      end
      default: begin
        o_wdata      = 32'd0;
        o_strb       = 4'd0;
        o_misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/memory_arbiter.sv
// Single-port memory arbiter: grants one fetch or data access at a time, holds
// the registered bus until mem_ready and bounds how long data may starve a fetch.
module memory_arbiter
  import common_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        iread,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dread,
  input  logic [1:0]  dwrite,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        derr,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_strb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t  r_state;
  arb_state_t  w_next_state;
  logic [3:0]  r_starve;
  logic [3:0]  w_next_starve;

  logic        r_mem_ren;
  logic        r_mem_wen;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_strb;
  logic        w_next_ren;
  logic        w_next_wen;
  logic [31:0] w_next_addr;
  logic [31:0] w_next_wdata;
  logic [3:0]  w_next_strb;

  logic        w_store;
  logic        w_dreq;
  logic        w_dvalid;
  logic        w_starved;
  logic        w_derr;
  logic [31:0] w_wdata;
  logic [3:0]  w_strb;
  logic        w_misaligned;

  store_align u_store_align (
    .i_size       (dwrite),
    .i_addr       (daddr[1:0]),
    .i_dstore     (dstore),
    .o_wdata      (w_wdata),
    .o_strb       (w_strb),
    .o_misaligned (w_misaligned)
  );

  assign w_store   = (dwrite != 2'b00);
  assign w_dreq    = dread | w_store;
  assign w_dvalid  = w_dreq & ~w_misaligned;
  assign w_starved = (r_starve >= LIMIT);

  // Grant arbitration in IDLE; hold the bus while busy until mem_ready
  always_comb begin
    w_next_state  = r_state;
    w_next_starve = r_starve;
    w_next_ren    = r_mem_ren;
    w_next_wen    = r_mem_wen;
    w_next_addr   = r_mem_addr;
    w_next_wdata  = r_mem_wdata;
    w_next_strb   = r_mem_strb;
    w_derr        = 1'b0;
    case (r_state)
      IDLE: begin
        w_derr       = w_dreq & w_misaligned;
        w_next_ren   = 1'b0;
        w_next_wen   = 1'b0;
        w_next_addr  = 32'd0;
        w_next_wdata = 32'd0;
        w_next_strb  = 4'd0;
        // A starved fetch beats a pending data request; otherwise data wins
        if (w_dvalid && !(iread && w_starved)) begin
          w_next_state  = DBUSY;
          w_next_starve = iread ? (r_starve + 4'd1) : 4'd0;
          w_next_ren    = ~w_store;
          w_next_wen    = w_store;
          w_next_addr   = word_align(daddr);
          w_next_wdata  = w_store ? w_wdata : 32'd0;
          w_next_strb   = w_store ? w_strb : 4'd0;
        end else if (iread) begin
          w_next_state  = IBUSY;
          w_next_starve = 4'd0;
          w_next_ren    = 1'b1;
          w_next_addr   = word_align(iaddr);
        end else begin
          w_next_state  = IDLE;
        end
      end
      IBUSY, DBUSY: begin
        if (mem_ready) begin
          w_next_state = IDLE;
          w_next_ren   = 1'b0;
          w_next_wen   = 1'b0;
          w_next_addr  = 32'd0;
          w_next_wdata = 32'd0;
          w_next_strb  = 4'd0;
        end else begin
          w_next_state = r_state;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_ren   = 1'b0;
        w_next_wen   = 1'b0;
        w_next_addr  = 32'd0;
        w_next_wdata = 32'd0;
        w_next_strb  = 4'd0;
      end
    endcase
  end

  // State, starve counter and registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_starve    <= 4'd0;
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_strb  <= 4'd0;
    end else begin
      r_state     <= w_next_state;
      r_starve    <= w_next_starve;
      r_mem_ren   <= w_next_ren;
      r_mem_wen   <= w_next_wen;
      r_mem_addr  <= w_next_addr;
      r_mem_wdata <= w_next_wdata;
      r_mem_strb  <= w_next_strb;
    end
  end

  // Hits and read data are gated by state so reset forces them low at once
  assign ihit      = (r_state == IBUSY) & mem_ready;
  assign dhit      = (r_state == DBUSY) & mem_ready;
  assign iload     = (r_state == IBUSY) ? mem_rdata : 32'd0;
  assign dload     = (r_state == DBUSY) ? mem_rdata : 32'd0;
  assign derr      = w_derr & ~rst;
  assign mem_ren   = r_mem_ren;
  assign mem_wen   = r_mem_wen;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_strb  = r_mem_strb;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a wait-state memory model answers the bus
// and every hit is checked against the expected access queued at stimulus time.
module tb_memory_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iread = 1'b0;
  logic [31:0] iaddr = 32'd0;
  logic        ihit;
  logic [31:0] iload;
  logic        dread = 1'b0;
  logic [1:0]  dwrite = 2'd0;
  logic [31:0] daddr = 32'd0;
  logic [31:0] dstore = 32'd0;
  logic        dhit;
  logic [31:0] dload;
  logic        derr;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cfg_wait = 0;
  int   wait_cnt = 0;
  bit   hold_req = 1'b0;
  int   n_ihit = 0;
  int   n_dhit = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .iread(iread), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dread(dread), .dwrite(dwrite), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload), .derr(derr),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_strb(mem_strb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'h0000_0013 : (a ^ 32'hDEAD_BEEF);
  endfunction

  task automatic push_exp(input logic is_d, input logic [31:0] a, input logic wen,
                          input logic [3:0] strb, input logic [31:0] wdata);
    exp_t e;
    e.is_d = is_d; e.addr = a; e.wen = wen; e.strb = strb; e.wdata = wdata;
    sb_q.push_back(e);
  endtask

  // One clock: memory model responds, then any hit is scored and its request dropped
  task automatic tick();
    exp_t e;
    @(posedge clk); #1;
    if (mem_ren || mem_wen) begin
      mem_rdata = mem_model(mem_addr);
      if (wait_cnt >= cfg_wait) mem_ready = 1'b1;
      else begin mem_ready = 1'b0; wait_cnt++; end
    end else begin
      mem_ready = 1'b0; mem_rdata = 32'd0; wait_cnt = 0;
    end
    #1;
    if (ihit || dhit) begin
      check_val("hit_exclusive", {31'd0, ihit & dhit}, 32'd0);
      check_val("sb_nonempty", {31'd0, sb_q.size() > 0}, 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_val("hit_kind", {31'd0, dhit}, {31'd0, e.is_d});
        check_val("hit_addr", mem_addr, e.addr);
        check_val("hit_wen", {31'd0, mem_wen}, {31'd0, e.wen});
        check_val("hit_ren", {31'd0, mem_ren}, {31'd0, ~e.wen});
        check_val("hit_strb", {28'd0, mem_strb}, {28'd0, e.strb});
        check_val("hit_wdata", mem_wdata, e.wdata);
        if (!e.wen) check_val("hit_rdata", dhit ? dload : iload, mem_model(e.addr));
      end
      if (ihit) begin n_ihit++; if (!hold_req) iread = 1'b0; end
      if (dhit) begin n_dhit++; if (!hold_req) begin dread = 1'b0; dwrite = 2'd0; end end
    end
  endtask

  task automatic wait_hits(input int target, input int budget);
    int k = 0;
    while ((n_ihit + n_dhit) < target && k < budget) begin
      tick();
      k++;
    end
    check_val("hits_reached", n_ihit + n_dhit, target);
  endtask

  task automatic do_data(input logic rd, input logic [1:0] wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] strb, input logic [31:0] wdata);
    int tgt;
    dread = rd; dwrite = wr; daddr = a; dstore = d;
    push_exp(1'b1, a & 32'hFFFF_FFFC, wr != 2'd0, strb, wdata);
    tgt = n_ihit + n_dhit + 1;
    wait_hits(tgt, 12);
    tick();
    check_val("bus_idle", {30'd0, mem_ren, mem_wen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int h0;
    int cnt;
    int base;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ren_wen", {30'd0, mem_ren, mem_wen}, 32'd0);
    check_val("rst_addr", mem_addr, 32'd0);
    check_val("rst_wdata_strb", mem_wdata | {28'd0, mem_strb}, 32'd0);
    check_val("rst_hits", {29'd0, ihit, dhit, derr}, 32'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Fetch-only, zero wait
    cfg_wait = 0; iread = 1'b1; iaddr = 32'h0000_0100;
    push_exp(1'b0, 32'h0000_0100, 1'b0, 4'd0, 32'd0);
    tick();
    check_val("f_ren", {31'd0, mem_ren}, 32'd1);
    check_val("f_addr", mem_addr, 32'h0000_0100);
    check_val("f_ihit", {31'd0, ihit}, 32'd1);
    check_val("f_iload", iload, 32'h0000_0013);
    tick();
    check_val("f_idle", {31'd0, mem_ren}, 32'd0);

    // Byte store with two wait states
    cfg_wait = 2; dwrite = 2'd1; daddr = 32'h0000_0203; dstore = 32'h0000_00AB;
    push_exp(1'b1, 32'h0000_0200, 1'b1, 4'b1000, 32'hABAB_ABAB);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val("b_wen", {31'd0, mem_wen}, 32'd1);
      check_val("b_addr", mem_addr, 32'h0000_0200);
      check_val("b_strb", {28'd0, mem_strb}, 32'h0000_0008);
      check_val("b_wdata", mem_wdata, 32'hABAB_ABAB);
      check_val("b_dhit", {31'd0, dhit}, (c == 2) ? 32'd1 : 32'd0);
    end
    tick();
    check_val("b_wen_drop", {31'd0, mem_wen}, 32'd0);

    // Aligned accesses of each size, one wait state
    cfg_wait = 1;
    do_data(1'b0, 2'd2, 32'h0000_0202, 32'hFFFF_1234, 4'b1100, 32'h1234_1234);
    do_data(1'b0, 2'd3, 32'h0000_0204, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    do_data(1'b0, 2'd1, 32'h0000_0201, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A);
    do_data(1'b1, 2'd2, 32'h0000_0210, 32'h0000_BEEF, 4'b0011, 32'hBEEF_BEEF);
    do_data(1'b1, 2'd0, 32'h0000_020C, 32'h1111_1111, 4'b0000, 32'h0000_0000);

    // Misaligned halfword with a fetch pending
    cfg_wait = 0; dwrite = 2'd2; daddr = 32'h0000_0201; dstore = 32'h0000_7777;
    iread = 1'b1; iaddr = 32'h0000_0140;
    push_exp(1'b0, 32'h0000_0140, 1'b0, 4'd0, 32'd0);
    #1;
    check_val("m_derr", {31'd0, derr}, 32'd1);
    tick();
    dwrite = 2'd0;
    check_val("m_derr_busy", {31'd0, derr}, 32'd0);
    check_val("m_ren_wen", {30'd0, mem_ren, mem_wen}, 32'd2);
    check_val("m_addr", mem_addr, 32'h0000_0140);
    tick();
    check_val("m_idle", {30'd0, mem_ren, mem_wen}, 32'd0);

    // Misaligned word alone: rejected, no access
    dwrite = 2'd3; daddr = 32'h0000_0206;
    #1;
    check_val("mw_derr", {31'd0, derr}, 32'd1);
    tick();
    check_val("mw_no_access", {30'd0, mem_ren, mem_wen}, 32'd0);
    dwrite = 2'd0;
    #1;
    check_val("mw_derr_clear", {31'd0, derr}, 32'd0);

    // Request withdrawn the cycle after grant
    cfg_wait = 1; dread = 1'b1; daddr = 32'h0000_0300;
    push_exp(1'b1, 32'h0000_0300, 1'b0, 4'd0, 32'd0);
    h0 = n_dhit;
    tick();
    dread = 1'b0;
    repeat (4) tick();
    check_val("w_one_dhit", n_dhit, h0 + 1);

    // Contention: both held, data may starve fetch at most LIMIT times
    cfg_wait = 0; hold_req = 1'b1;
    iread = 1'b1; iaddr = 32'h0000_0400; dread = 1'b1; daddr = 32'h0000_0500;
    cnt = 0;
    for (int g = 0; g < 10; g++) begin
      if (cnt < LIMIT) begin push_exp(1'b1, 32'h0000_0500, 1'b0, 4'd0, 32'd0); cnt++; end
      else begin push_exp(1'b0, 32'h0000_0400, 1'b0, 4'd0, 32'd0); cnt = 0; end
    end
    base = n_ihit + n_dhit;
    wait_hits(base + 10, 40);
    hold_req = 1'b0; iread = 1'b0; dread = 1'b0;
    repeat (2) tick();
    check_val("sb_drained", sb_q.size(), 32'd0);

    // Reset asserted mid-DBUSY
    cfg_wait = 20; dread = 1'b1; daddr = 32'h0000_0600;
    h0 = n_dhit;
    tick();
    check_val("r_busy", {31'd0, mem_ren}, 32'd1);
    #2 rst = 1'b1;
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    check_val("r_ren_wen", {30'd0, mem_ren, mem_wen}, 32'd0);
    check_val("r_addr", mem_addr, 32'd0);
    check_val("r_no_dhit", {31'd0, dhit}, 32'd0);
    check_val("r_dload", dload, 32'd0);
    dread = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (3) tick();
    check_val("r_dhit_count", n_dhit, h0);
    check_val("r_idle", {30'd0, mem_ren, mem_wen}, 32'd0);
    check_val("sb_final", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester arbiter and sequencer for the core's single memory port. It accepts instruction fetches and data loads/stores driven by the control unit's `dread`/`dwrite` outputs, and grants one transaction at a time. It holds the memory bus stable until the memory signals completion, then returns a hit to the winning requester. It sits between the fetch/request units and the memory/bus interface.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: maximum consecutive data grants while a fetch is pending before the fetch is forced through (1..15).

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `iread`  in  1  instruction fetch request; held until `ihit`.
- `iaddr`  in  32  fetch address, word aligned.
- `ihit`  out  1  fetch complete; `iload` valid this cycle.
- `iload`  out  32  fetch data.
- `dread`  in  1  data load request; held until `dhit`.
- `dwrite`  in  2  store size: 0 none, 1 byte, 2 halfword, 3 word; held until `dhit`.
- `daddr`  in  32  data byte address.
- `dstore`  in  32  store data, right-justified.
- `dhit`  out  1  data access complete; `dload` valid this cycle for loads.
- `dload`  out  32  raw word read from memory.
- `derr`  out  1  one-cycle pulse: misaligned data request rejected.
- `mem_ren`, `mem_wen`  out  1  memory read / write enable.
- `mem_addr`  out  32  word-aligned address (`[1:0]` = 0).
- `mem_wdata`  out  32  lane-aligned store data.
- `mem_strb`  out  4  byte-write strobes.
- `mem_rdata`  in  32  memory read data.
- `mem_ready`  in  1  memory completes the current access this cycle.

## Operation
- FSM states are IDLE, IBUSY and DBUSY. Reset puts the FSM in IDLE, the starve counter at 0, and every output at 0.
- In IDLE, the arbiter samples requests. A data request is `dread | (dwrite != 0)`. Grant rules:
  - Data only: go to DBUSY.
  - Fetch only: go to IBUSY.
  - Both, with starve counter < `STARVE_LIMIT`: grant data and increment the counter.
  - Both, with counter = `STARVE_LIMIT`: grant the fetch.
- Starve counter:
  - Clears on any fetch grant.
  - Clears on a data grant with no fetch pending.
  - Saturates at `STARVE_LIMIT`.
- Misalignment: a halfword with `daddr[0]` = 1, or a word with `daddr[1:0]` != 0, is rejected.
  - In IDLE the arbiter pulses `derr` for one cycle and stays IDLE; no memory access occurs.
  - A simultaneous fetch is granted in that same cycle.
- On grant, the arbiter registers the bus outputs: `mem_addr = {addr[31:2],2'b00}`, the enables, `mem_wdata`, and `mem_strb`.
  - Byte strobe: `1 << a[1:0]`. Halfword strobe: `4'b0011 << a[1:0]`. Word strobe: `4'b1111`.
  - `mem_wdata` replicates the byte or halfword across all lanes.
  - `dread` with `dwrite` != 0 is treated as a store.
- In IBUSY/DBUSY the bus outputs are held constant until `mem_ready`.
  - `ihit`/`dhit` = state match & `mem_ready`, combinational.
  - `iload`/`dload` pass `mem_rdata` through.
  - Next state is IDLE; the enables drop to 0 in the next cycle.
- A request withdrawn mid-transaction has no effect; the committed access completes and the hit is still pulsed.
- `mem_ready` in IDLE is ignored.

## Timing
- Cycle N: request seen in IDLE, grant registered.
- Cycle N+1: bus valid. Earliest `mem_ready`/hit is N+1.
- Cycle N+2: IDLE again; the next request can be sampled.
- Zero-wait throughput is one access per 2 cycles. Each wait cycle adds 1.
- `derr` appears in the cycle the misaligned request is sampled.
- Reset asserted mid-transaction: outputs go to 0 asynchronously and no hit is issued. The requester re-issues after reset.

## Structure
- `common_types_pkg` holds:
  - `mem_size_t` (NONE/BYTE/HALF/WORD, 2 bits), which also gives the meaning of the `dwrite` encoding.
  - `arb_state_t` (IDLE/IBUSY/DBUSY).
- Sub-module `store_align` is combinational. It takes size, `addr[1:0]` and `dstore`, and produces `wdata`, `strb` and `misaligned`.

## Test plan
- Reset: assert `rst` mid-DBUSY → all outputs 0 at once, FSM IDLE, no `dhit`.
- Fetch-only, `iaddr`=0x100, `mem_ready` tied 1, `mem_rdata`=0x00000013 → `mem_ren`/`mem_addr`=0x100 at N+1, `ihit`=1 with `iload`=0x13 at N+1, IDLE at N+2.
- Byte store: `dwrite`=1, `daddr`=0x203, `dstore`=0xAB, 2 wait states → `mem_addr`=0x200, `mem_strb`=4'b1000, `mem_wdata`=0xABABABAB held 3 cycles; `dhit` on the 3rd bus cycle.
- Misaligned halfword at 0x201, fetch also pending → `derr` pulse, no `mem_wen`, fetch granted that same cycle.
- Contention: `iread` and `dread` held continuously, `STARVE_LIMIT`=4 → grant sequence D,D,D,D,I,D,D,D,D,I…
- Withdrawn request: drop `dread` in the cycle after grant → access still completes and `dhit` pulses once.
